mmio_io_ctrl: RTL

- Memory-mapped peripheral controller on the downstream side of the CPU IO bus.
- Decodes io_addr / io_we / io_rd and holds the output registers (LEDs, display word).
- Captures switch input on a button press with a valid-flag handshake, and runs a free-running cycle counter.
- Returns read data on io_din combinationally, because the CPU samples io_din in the same cycle as io_rd.

---
 rtl/mmio_io_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO controller: LED and display output registers, button-triggered
// switch capture with valid/overflow flags, and a prescaled free-running cycle counter.
`timescale 1ns/1ps
module mmio_io_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CNT_PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  input  logic        disp_ack
);

  localparam logic [5:0] ADDR_LED      = 6'h00;
  localparam logic [5:0] ADDR_IN_STAT  = 6'h01;
  localparam logic [5:0] ADDR_DISP     = 6'h02;
  localparam logic [5:0] ADDR_DISP_RDY = 6'h03;
  localparam logic [5:0] ADDR_IN_DATA  = 6'h04;
  localparam logic [5:0] ADDR_CNT      = 6'h05;
  localparam logic [5:0] ADDR_CNT_CLR  = 6'h06;

  logic [5:0]             word;
  logic                   unused_addr_lsb;
  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_prev;
  logic                   pulse;
  logic [31:0]            in_data;
  logic                   in_vld;
  logic                   in_ovf;
  logic [31:0]            cnt;
  logic [31:0]            pre;
  logic                   rd_in_data;
  logic                   we_led;
  logic                   we_disp;
  logic                   we_clr;

  assign word            = io_addr[7:2];
  assign unused_addr_lsb = ^io_addr[1:0];

  assign rd_in_data = io_rd && (word == ADDR_IN_DATA);
  assign we_led     = io_we && (word == ADDR_LED);
  assign we_disp    = io_we && (word == ADDR_DISP);
  assign we_clr     = io_we && (word == ADDR_CNT_CLR);

  // Edge pulse is registered so it lands one edge after the synchronizer output rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync     <= '0;
      btn_prev <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], btn};
      btn_prev <= sync[SYNC_STAGES-1];
      pulse    <= sync[SYNC_STAGES-1] & ~btn_prev;
    end
  end

  // A capture coinciding with a data read replaces the word just read and keeps it valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_data <= '0;
      in_vld  <= 1'b0;
      in_ovf  <= 1'b0;
    end else if (pulse) begin
      if (!in_vld || rd_in_data) begin
        in_data <= {16'b0, sw};
        in_vld  <= 1'b1;
        if (rd_in_data) in_ovf <= 1'b0;
      end else begin
        in_ovf <= 1'b1;
      end
    end else if (rd_in_data) begin
      in_vld <= 1'b0;
      in_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led        <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      if (we_led) led <= io_dout[15:0];
      if (disp_valid) begin
        if (disp_ack) disp_valid <= 1'b0;
      end else if (we_disp) begin
        disp_data  <= io_dout;
        disp_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      pre <= '0;
    end else if (we_clr) begin
      cnt <= '0;
      pre <= '0;
    end else if (pre == CNT_PRESCALE - 1) begin
      pre <= '0;
      cnt <= cnt + 32'd1;
    end else begin
      pre <= pre + 32'd1;
    end
  end

  always_comb begin
    io_din = '0;
    case (word)
      ADDR_IN_STAT:  io_din = {30'b0, in_ovf, in_vld};
      ADDR_DISP_RDY: io_din = {31'b0, ~disp_valid};
      ADDR_IN_DATA:  io_din = in_data;
      ADDR_CNT:      io_din = cnt;
      default:       io_din = '0;
    endcase
  end

endmodule
